// File: rtl/bist_ram_responder.sv
// bist_ram_responder
// RAM model with a programmable fault table, used in place of the plain RAM
// so the BIST initiator can be exercised against known defects. It has one
// write port and one registered read port with read-first behaviour. Stuck-at
// faults corrupt the read path, and flip faults corrupt the stored word on
// write. A saturating counter records reads whose data was corrupted.

module bist_ram_responder #(
    parameter  int ADDR_W     = 10,
    parameter  int DATA_W     = 8,
    parameter  int NUM_FAULTS = 2,
    localparam int FI_W       = ($clog2(NUM_FAULTS) > 1) ? $clog2(NUM_FAULTS) : 1,
    localparam int BIT_W      = ($clog2(DATA_W) > 1) ? $clog2(DATA_W) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addrs,
    input  logic [ADDR_W-1:0] wrt_addrs,
    input  logic              wrt_en,
    input  logic [DATA_W-1:0] wrt_dat,
    output logic [DATA_W-1:0] rd_data,
    input  logic              flt_load,
    input  logic [FI_W-1:0]   flt_idx,
    input  logic [ADDR_W-1:0] flt_addr,
    input  logic [BIT_W-1:0]  flt_bit,
    input  logic [1:0]        flt_type,
    output logic              flt_ack,
    output logic [7:0]        fault_hits
);

    // Fault kinds as encoded on flt_type.
    typedef enum logic [1:0] {
        FLT_OFF  = 2'b00,
        FLT_SA0  = 2'b01,
        FLT_SA1  = 2'b10,
        FLT_FLIP = 2'b11
    } flt_kind_e;

    typedef struct packed {
        flt_kind_e         kind;
        logic [ADDR_W-1:0] addr;
        logic [BIT_W-1:0]  bit_pos;
    } flt_entry_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } load_state_e;

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    flt_entry_t        flt_tbl [NUM_FAULTS];

    load_state_e       state_q;
    load_state_e       state_d;
    logic              load_go;

    logic [DATA_W-1:0] wr_word;
    logic [DATA_W-1:0] rd_raw;
    logic [DATA_W-1:0] rd_faulted;
    logic              rd_hit;

    // Load handshake: next state and Moore outputs.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        flt_ack = 1'b0;
        load_go = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (flt_load) begin
                    load_go = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                flt_ack = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Load handshake state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    // Fault table: cleared on reset. An accepted load writes only an in-range
    // index. An out-of-range index is still acknowledged but leaves the table unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_FAULTS; i++) begin
                flt_tbl[i] <= '{kind: FLT_OFF, addr: '0, bit_pos: '0};
            end
        end else if (load_go) begin
            for (int i = 0; i < NUM_FAULTS; i++) begin
                if (int'(flt_idx) == i) begin
                    flt_tbl[i] <= '{kind: flt_kind_e'(flt_type), addr: flt_addr, bit_pos: flt_bit};
                end
            end
        end
    end

    // Write data after flip-on-write faults. Each matching flip entry inverts
    // its bit, so two flips on the same bit cancel.
    always_comb begin
        wr_word = wrt_dat;
        for (int i = 0; i < NUM_FAULTS; i++) begin
            if (flt_tbl[i].kind == FLT_FLIP && flt_tbl[i].addr == wrt_addrs) begin
                wr_word[flt_tbl[i].bit_pos] = ~wr_word[flt_tbl[i].bit_pos];
            end
        end
    end

    // Read data after stuck-at faults. Entries are applied from the highest
    // index down, so the lowest index wins when SA0 and SA1 target the same bit.
    always_comb begin
        rd_raw     = mem[rd_addrs];
        rd_faulted = rd_raw;
        for (int i = NUM_FAULTS - 1; i >= 0; i--) begin
            if (flt_tbl[i].addr == rd_addrs) begin
                if (flt_tbl[i].kind == FLT_SA0) begin
                    rd_faulted[flt_tbl[i].bit_pos] = 1'b0;
                end else if (flt_tbl[i].kind == FLT_SA1) begin
                    rd_faulted[flt_tbl[i].bit_pos] = 1'b1;
                end
            end
        end
        rd_hit = (rd_faulted != rd_raw);
    end

    // Storage array write port.
    // NOTE: the array has no reset; its contents deliberately survive rst, as a real RAM's would.
    always_ff @(posedge clk) begin
        if (wrt_en) begin
            mem[wrt_addrs] <= wr_word;
        end
    end

    // Registered read data. This samples the array before this edge's write
    // lands, which gives read-first behaviour on a same-address collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_faulted;
        end
    end

    // Saturating count of corrupted reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_hits <= '0;
        end else if (rd_hit && fault_hits != 8'hFF) begin
            fault_hits <= fault_hits + 8'd1;
        end
    end

endmodule
